// File: rtl/ib_pkg.sv
// ib_pkg: shared state encoding and P6/P7 bit positions for the IB handshake scheduler.
package ib_pkg;
    typedef enum logic [2:0] {
        IDLE,
        R_LOAD,
        R_PRESENT,
        R_WAIT_REL,
        W_CAPTURE,
        W_PUSH,
        W_WAIT_REL
    } state_e;

    localparam int P7_MODE  = 0;
    localparam int P7_RDCMP = 1;
    localparam int P7_WRAV  = 2;
    localparam int P6_NDAV  = 0;
    localparam int P6_NWACC = 3;

    localparam logic [3:0] P6_IDLE = 4'b1001;
endpackage

// File: rtl/ib_timeout_cnt.sv
// ib_timeout_cnt: counts cycles spent in a wait state; expire_o fires on the last allowed cycle.
module ib_timeout_cnt #(
    parameter int TW             = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    logic [TW-1:0] cnt_q;

    assign expire_o = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (clr_i)
            cnt_q <= '0;
        else if (en_i && !expire_o)
            cnt_q <= cnt_q + TW'(1);
    end
endmodule

// File: rtl/ib_handshake_sched.sv
// ib_handshake_sched: moves bytes between the UART FIFOs and the MCU nibble ports P4-P7
// using the P6/P7 read and write handshakes.
module ib_handshake_sched
    import ib_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TW             = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] p7_reg,
    input  logic [3:0] p4_reg,
    input  logic [3:0] p5_reg,
    output logic [3:0] p4_rd,
    output logic [3:0] p5_rd,
    output logic [3:0] p6_rd,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_pop,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       err_timeout
);
    state_e     state_q, state_d;
    logic [7:0] hold_q, hold_d, tx_data_q, tx_data_d;
    logic [3:0] p4_q, p4_d, p5_q, p5_d;
    logic       hold_valid_q, hold_valid_d, err_q, err_d;
    logic       mode, rdcmp, wrav, timed, expire;

    assign mode  = p7_reg[P7_MODE];
    assign rdcmp = p7_reg[P7_RDCMP];
    assign wrav  = p7_reg[P7_WRAV];
    assign timed = state_q inside {R_PRESENT, R_WAIT_REL, W_PUSH, W_WAIT_REL};

    ib_timeout_cnt #(.TW(TW), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (state_d != state_q),
        .en_i    (timed),
        .expire_o(expire)
    );

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        tx_data_d    = tx_data_q;
        err_d        = err_q;
        case (state_q)
            IDLE:
                if (!mode)
                    state_d = hold_valid_q ? R_PRESENT : (rx_valid ? R_LOAD : IDLE);
                else if (!wrav)
                    state_d = W_CAPTURE;
            R_LOAD: begin
                // The pop has already happened, so the byte is kept even if the mode flips now.
                hold_d       = rx_data;
                hold_valid_d = 1'b1;
                state_d      = mode ? IDLE : R_PRESENT;
            end
            R_PRESENT:
                if (mode)
                    state_d = IDLE;
                else if (!rdcmp) begin
                    hold_valid_d = 1'b0;
                    state_d      = R_WAIT_REL;
                end
            R_WAIT_REL:
                if (mode || rdcmp)
                    state_d = IDLE;
            W_CAPTURE: begin
                tx_data_d = {p5_reg, p4_reg};
                state_d   = mode ? W_PUSH : IDLE;
            end
            W_PUSH:
                if (tx_ready)
                    state_d = W_WAIT_REL;
            W_WAIT_REL:
                if (!mode || wrav)
                    state_d = IDLE;
            default:
                state_d = IDLE;
        endcase
        // A real transition in the same cycle wins over the timeout.
        if (expire && state_d == state_q) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
        p4_d = (state_d == R_PRESENT) ? hold_d[3:0] : p4_q;
        p5_d = (state_d == R_PRESENT) ? hold_d[7:4] : p5_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            tx_data_q    <= '0;
            p4_q         <= '0;
            p5_q         <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            tx_data_q    <= tx_data_d;
            p4_q         <= p4_d;
            p5_q         <= p5_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        p6_rd           = P6_IDLE;
        p6_rd[P6_NDAV]  = state_q != R_PRESENT;
        p6_rd[P6_NWACC] = state_q != W_WAIT_REL;
    end

    assign p4_rd       = p4_q;
    assign p5_rd       = p5_q;
    assign rx_pop      = state_q == R_LOAD;
    assign tx_valid    = state_q == W_PUSH;
    assign tx_data     = tx_data_q;
    assign busy        = state_q != IDLE;
    assign err_timeout = err_q;
endmodule

// File: tb/tb_ib_handshake_sched.sv
// tb_ib_handshake_sched: vector table, directed corner sequences and a randomized
// byte-stream scoreboard for ib_handshake_sched.
module tb_ib_handshake_sched;
    logic       clk, rst_n;
    logic [3:0] p7_reg, p4_reg, p5_reg, p4_rd, p5_rd, p6_rd;
    logic [7:0] rx_data, tx_data;
    logic       rx_valid, rx_pop, tx_valid, tx_ready, busy, err_timeout;

    int errs = 0, total = 0, pops = 0;
    logic [7:0] rxq[$], tx_log[$], sent[$], exp_tx[$];

    ib_handshake_sched #(.TIMEOUT_CYCLES(100), .TW(16)) dut (
        .clk(clk), .rst_n(rst_n), .p7_reg(p7_reg), .p4_reg(p4_reg), .p5_reg(p5_reg),
        .p4_rd(p4_rd), .p5_rd(p5_rd), .p6_rd(p6_rd), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_pop(rx_pop), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] p7, p4, p5;
        logic       rdy;
        logic       busy, txv;
        logic [7:0] txd;
        logic [3:0] p6;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic refresh_rx();
        rx_valid = rxq.size() != 0;
        rx_data  = rx_valid ? rxq[0] : 8'h00;
    endtask

    // One clock: record FIFO/TX handshakes seen at the edge, then settle 1 time unit.
    task automatic step();
        logic pop_now;
        pop_now = rx_pop;
        if (tx_valid && tx_ready) tx_log.push_back(tx_data);
        @(posedge clk);
        #1;
        if (pop_now && rxq.size() > 0) begin
            void'(rxq.pop_front());
            pops++;
        end
        refresh_rx();
    endtask

    task automatic wait_present();
        int n;
        n = 0;
        while (p6_rd[0] && n < 50) begin
            step();
            n++;
        end
        chk("present_wait", p6_rd[0], 1'b0);
    endtask

    task automatic read_byte(output logic [7:0] b);
        wait_present();
        b = {p5_rd, p4_rd};
        p7_reg = 4'b1100;
        step();
        chk("ack_p6", p6_rd, 4'b1001);
        p7_reg = 4'b1110;
        step();
    endtask

    initial begin
        vec_t tbl[15];
        logic [7:0] b, d;
        logic last_err;
        int n, p0, t0, g, nreads;

        tbl[0]  = '{4'b1111, 4'h4, 4'h4, 1'b0, 1'b0, 1'b0, 8'h00, 4'b1001};
        tbl[1]  = '{4'b1011, 4'h4, 4'h4, 1'b0, 1'b1, 1'b0, 8'h00, 4'b1001};
        tbl[2]  = '{4'b1011, 4'h4, 4'h4, 1'b0, 1'b1, 1'b1, 8'h44, 4'b1001};
        tbl[3]  = '{4'b1011, 4'h4, 4'h4, 1'b0, 1'b1, 1'b1, 8'h44, 4'b1001};
        tbl[4]  = '{4'b1011, 4'h4, 4'h4, 1'b1, 1'b1, 1'b0, 8'h44, 4'b0001};
        tbl[5]  = '{4'b1011, 4'h4, 4'h4, 1'b0, 1'b1, 1'b0, 8'h44, 4'b0001};
        tbl[6]  = '{4'b1111, 4'h4, 4'h4, 1'b0, 1'b0, 1'b0, 8'h44, 4'b1001};
        tbl[7]  = '{4'b1011, 4'hA, 4'h3, 1'b1, 1'b1, 1'b0, 8'h44, 4'b1001};
        tbl[8]  = '{4'b1011, 4'hA, 4'h3, 1'b1, 1'b1, 1'b1, 8'h3A, 4'b1001};
        tbl[9]  = '{4'b1011, 4'hA, 4'h3, 1'b1, 1'b1, 1'b0, 8'h3A, 4'b0001};
        tbl[10] = '{4'b1010, 4'hA, 4'h3, 1'b0, 1'b0, 1'b0, 8'h3A, 4'b1001};
        tbl[11] = '{4'b1010, 4'hA, 4'h3, 1'b0, 1'b0, 1'b0, 8'h3A, 4'b1001};
        tbl[12] = '{4'b1110, 4'hA, 4'h3, 1'b0, 1'b0, 1'b0, 8'h3A, 4'b1001};
        tbl[13] = '{4'b1010, 4'hA, 4'h3, 1'b0, 1'b0, 1'b0, 8'h3A, 4'b1001};
        tbl[14] = '{4'b1110, 4'hA, 4'h3, 1'b0, 1'b0, 1'b0, 8'h3A, 4'b1001};

        rst_n = 1'b0; p7_reg = 4'b1111; p4_reg = '0; p5_reg = '0; tx_ready = 1'b0;
        refresh_rx();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_p4", p4_rd, 4'h0);
        chk("rst_p5", p5_rd, 4'h0);
        chk("rst_p6", p6_rd, 4'b1001);
        chk("rst_flags", {rx_pop, tx_valid, busy, err_timeout}, 4'b0000);
        chk("rst_txd", tx_data, 8'h00);
        rst_n = 1'b1;

        // Write handshakes and idle read-mode strobes, cycle by cycle.
        for (int i = 0; i < 15; i++) begin
            p7_reg = tbl[i].p7; p4_reg = tbl[i].p4; p5_reg = tbl[i].p5; tx_ready = tbl[i].rdy;
            step();
            chk($sformatf("vec%0d", i), {busy, tx_valid, tx_data, p6_rd},
                {tbl[i].busy, tbl[i].txv, tbl[i].txd, tbl[i].p6});
        end
        chk("vec_txcnt", tx_log.size(), 2);
        if (tx_log.size() == 2) chk("vec_txbytes", {tx_log[0], tx_log[1]}, 16'h443A);
        tx_log.delete();

        // Read stream DE AD BE EF.
        p0 = pops;
        p7_reg = 4'b1110;
        rxq.push_back(8'hDE); rxq.push_back(8'hAD); rxq.push_back(8'hBE); rxq.push_back(8'hEF);
        refresh_rx();
        n = 0;
        while (p6_rd[0] && n < 10) begin
            step();
            n++;
        end
        chk("rd_latency", n, 2);
        read_byte(b); chk("rd0", b, 8'hDE);
        read_byte(b); chk("rd1", b, 8'hAD);
        read_byte(b); chk("rd2", b, 8'hBE);
        read_byte(b); chk("rd3", b, 8'hEF);
        repeat (3) step();
        chk("rd_pops", pops - p0, 4);
        chk("rd_idle", {busy, p6_rd}, {1'b0, 4'b1001});

        // Mode flip while a byte is presented: it must come back, with no extra pop.
        p0 = pops;
        rxq.push_back(8'h5A);
        refresh_rx();
        wait_present();
        chk("mc_first", {p5_rd, p4_rd}, 8'h5A);
        p7_reg = 4'b1111;
        step();
        chk("mc_abort", {busy, p6_rd}, {1'b0, 4'b1001});
        repeat (3) step();
        p7_reg = 4'b1110;
        read_byte(b);
        chk("mc_again", b, 8'h5A);
        chk("mc_pops", pops - p0, 1);

        // TX stalled in W_PUSH until the 100-cycle timeout.
        t0 = tx_log.size();
        p7_reg = 4'b1111; p4_reg = 4'h7; p5_reg = 4'h1; tx_ready = 1'b0;
        step();
        p7_reg = 4'b1011;
        step();
        step();
        p7_reg = 4'b1111;
        chk("to_push", {tx_valid, tx_data}, {1'b1, 8'h17});
        n = 0;
        last_err = 1'b1;
        while (tx_valid && n < 300) begin
            last_err = err_timeout;
            n++;
            step();
        end
        chk("to_cycles", n, 100);
        chk("to_err_before", last_err, 1'b0);
        chk("to_after", {err_timeout, tx_valid, busy, p6_rd}, {3'b100, 4'b1001});
        repeat (3) step();
        chk("to_sticky", err_timeout, 1'b1);
        chk("to_no_tx", tx_log.size(), t0);

        // Asynchronous reset while presenting a byte.
        p7_reg = 4'b1110;
        rxq.push_back(8'hC3);
        refresh_rx();
        wait_present();
        chk("rs_present", {p5_rd, p4_rd}, 8'hC3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_ports", {p4_rd, p5_rd, p6_rd}, 12'h009);
        chk("rs_flags", {rx_pop, tx_valid, busy, err_timeout}, 4'b0000);
        chk("rs_txd", tx_data, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) step();
        chk("rs_lost", {busy, p6_rd}, {1'b0, 4'b1001});

        // Random mix of reads (with mode glitches) and writes against in-order byte queues.
        tx_log.delete();
        p0 = pops;
        nreads = 0;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(1, 0) == 1) begin
                b = 8'($urandom);
                rxq.push_back(b);
                sent.push_back(b);
                refresh_rx();
                nreads++;
                p7_reg = 4'b1110;
                g = $urandom_range(2, 0);
                if (g == 1) begin
                    step();
                    p7_reg = 4'b1111;
                    step();
                    step();
                    p7_reg = 4'b1110;
                end else if (g == 2) begin
                    wait_present();
                    p7_reg = 4'b1111;
                    repeat ($urandom_range(3, 1)) step();
                    p7_reg = 4'b1110;
                end
                read_byte(b);
                chk("rnd_rd", b, sent.pop_front());
            end else begin
                d = 8'($urandom);
                exp_tx.push_back(d);
                p4_reg = d[3:0]; p5_reg = d[7:4]; p7_reg = 4'b1011; tx_ready = 1'b0;
                step();
                step();
                repeat ($urandom_range(5, 0)) step();
                tx_ready = 1'b1;
                n = 0;
                while (p6_rd[3] && n < 20) begin
                    step();
                    n++;
                end
                tx_ready = 1'b0;
                chk("rnd_wr_ack", p6_rd[3], 1'b0);
                p7_reg = 4'b1111;
                step();
                chk("rnd_wr_rel", p6_rd, 4'b1001);
            end
        end
        chk("rnd_pops", pops - p0, nreads);
        chk("rnd_txcnt", tx_log.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
            chk("rnd_tx", tx_log[i], exp_tx[i]);
        chk("rnd_err", err_timeout, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, total);
        $finish;
    end
endmodule
